// File: rtl/panamax_fpga_cfg_loader.sv
// Panamax FPGA configuration loader: wakes SPI NOR flash, issues a read and
// streams a fixed-length bitstream bit-serially into the configuration chain.
module panamax_fpga_cfg_loader #(
    parameter int unsigned BITSTREAM_BITS = 4096,
    parameter logic [23:0] FLASH_ADDR     = 24'h000000,
    parameter int unsigned WAKE_GAP       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fpga_mode_i,
    output logic spi_sclk_o,
    output logic spi_cs_n_o,
    output logic spi_mosi_o,
    input  logic spi_miso_i,
    output logic config_busy_o,
    output logic cfg_data_o,
    output logic cfg_we_o,
    output logic cfg_done_o
);

    localparam int unsigned CW_B = $clog2(BITSTREAM_BITS);
    localparam int unsigned CW_G = $clog2(WAKE_GAP);
    localparam int unsigned CW_M = (CW_B > CW_G) ? CW_B : CW_G;
    // At least 5 bits so the 24-bit address phase fits
    localparam int unsigned CW   = (CW_M > 5) ? CW_M : 5;

    localparam logic [7:0] CMD_WAKE = 8'hAB;
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_WAKE, S_GAP, S_CMD, S_ADDR, S_DATA, S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [31:0]     r_sr, w_sr;
    logic            r_samp, w_samp;
    logic            r_sclk, w_sclk;
    logic            r_cs_n, w_cs_n;
    logic            r_mosi, w_mosi;
    logic            r_busy, w_busy;
    logic            r_cfg_data, w_cfg_data;
    logic            r_cfg_we, w_cfg_we;
    logic            r_cfg_done, w_cfg_done;
    logic [CW-1:0]   w_last;

    // State and output registers; reset releases the flash immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_samp     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_data <= 1'b0;
            r_cfg_we   <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sr       <= w_sr;
            r_samp     <= w_samp;
            r_sclk     <= w_sclk;
            r_cs_n     <= w_cs_n;
            r_mosi     <= w_mosi;
            r_busy     <= w_busy;
            r_cfg_data <= w_cfg_data;
            r_cfg_we   <= w_cfg_we;
            r_cfg_done <= w_cfg_done;
        end
    end

    // Last bit index of the current serial phase
    always_comb begin
        w_last = '0;
        case (r_state)
            S_WAKE:  w_last = CW'(7);
            S_CMD:   w_last = CW'(7);
            S_ADDR:  w_last = CW'(23);
            S_DATA:  w_last = CW'(BITSTREAM_BITS - 1);
            default: w_last = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sr       = r_sr;
        w_samp     = r_samp;
        w_sclk     = r_sclk;
        w_cs_n     = r_cs_n;
        w_mosi     = r_mosi;
        w_busy     = r_busy;
        w_cfg_data = r_cfg_data;
        w_cfg_we   = 1'b0;
        w_cfg_done = r_cfg_done;

        case (r_state)
            S_IDLE: begin
                if (fpga_mode_i) begin
                    w_state = S_WAKE;
                    w_cs_n  = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = '0;
                    w_sclk  = 1'b0;
                    w_sr    = {CMD_WAKE, 24'h000000};
                    w_mosi  = CMD_WAKE[7];
                end
            end

            S_WAKE, S_CMD, S_ADDR, S_DATA: begin
                if (!r_sclk) begin
                    // Phase L -> H: rising SCLK, capture flash output
                    w_sclk = 1'b1;
                    if (r_state == S_DATA) begin
                        w_samp = spi_miso_i;
                    end
                end else begin
                    // Phase H -> L: falling SCLK, present next bit
                    w_sclk = 1'b0;
                    w_sr   = {r_sr[30:0], 1'b0};
                    w_mosi = r_sr[30];
                    w_cnt  = r_cnt + CW'(1);
                    if (r_state == S_DATA) begin
                        w_mosi     = 1'b0;
                        w_cfg_we   = 1'b1;
                        w_cfg_data = r_samp;
                    end
                    if (r_cnt == w_last) begin
                        w_cnt = '0;
                        case (r_state)
                            S_WAKE: begin
                                w_state = S_GAP;
                                w_cs_n  = 1'b1;
                                w_mosi  = 1'b0;
                            end
                            // Command and address share one shift register
                            S_CMD:  w_state = S_ADDR;
                            S_ADDR: begin
                                w_state = S_DATA;
                                w_mosi  = 1'b0;
                            end
                            default: begin
                                w_state    = S_DONE;
                                w_cs_n     = 1'b1;
                                w_busy     = 1'b0;
                                w_cfg_done = 1'b1;
                            end
                        endcase
                    end
                end
            end

            S_GAP: begin
                if (r_cnt == CW'(WAKE_GAP - 1)) begin
                    w_state = S_CMD;
                    w_cnt   = '0;
                    w_cs_n  = 1'b0;
                    w_sr    = {CMD_READ, FLASH_ADDR};
                    w_mosi  = CMD_READ[7];
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_DONE: begin
                w_state = S_DONE;
            end

            default: w_state = S_IDLE;
        endcase
    end

    assign spi_sclk_o    = r_sclk;
    assign spi_cs_n_o    = r_cs_n;
    assign spi_mosi_o    = r_mosi;
    assign config_busy_o = r_busy;
    assign cfg_data_o    = r_cfg_data;
    assign cfg_we_o      = r_cfg_we;
    assign cfg_done_o    = r_cfg_done;

endmodule

// File: tb/tb_panamax_fpga_cfg_loader.sv
// Bench for panamax_fpga_cfg_loader: behavioural SPI flash plus scoreboards
// for flash transactions and delivered configuration bits.
module tb_panamax_fpga_cfg_loader;

    localparam int unsigned BITS     = 32;
    localparam logic [23:0] ADDR     = 24'h100000;
    localparam int unsigned GAP      = 8;
    localparam int unsigned BUSY_LEN = 16 + GAP + 2 * (8 + 24 + BITS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic sclk, cs_n, mosi, busy, cfg_data, cfg_we, cfg_done;
    logic miso = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    panamax_fpga_cfg_loader #(
        .BITSTREAM_BITS(BITS),
        .FLASH_ADDR    (ADDR),
        .WAKE_GAP      (GAP)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fpga_mode_i  (mode),
        .spi_sclk_o   (sclk),
        .spi_cs_n_o   (cs_n),
        .spi_mosi_o   (mosi),
        .spi_miso_i   (miso),
        .config_busy_o(busy),
        .cfg_data_o   (cfg_data),
        .cfg_we_o     (cfg_we),
        .cfg_done_o   (cfg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flash contents: the bitstream word stored at a given byte address
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return (a == 24'h100000) ? 32'hDEADBEEF : 32'h12345678;
    endfunction

    // ---------------- SPI flash model (mode 0) ----------------
    int          fl_cnt = 0;
    logic [63:0] fl_sr  = '0;
    logic [7:0]  fl_cmd = '0;
    logic [23:0] fl_addr = '0;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        bit          chk_addr;
        int          bits;     // 0 = aborted session, length not checked
    } sess_t;
    sess_t exp_sess[$];
    logic  exp_bits[$];

    always @(negedge cs_n) begin
        fl_cnt  = 0;
        fl_sr   = '0;
        fl_cmd  = '0;
        fl_addr = '0;
    end

    always @(posedge sclk) begin
        if (cs_n === 1'b0) begin
            fl_sr = {fl_sr[62:0], mosi};
            fl_cnt++;
            if (fl_cnt == 8)  fl_cmd  = fl_sr[7:0];
            if (fl_cnt == 32) fl_addr = fl_sr[23:0];
        end
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0 && fl_cmd == 8'h03 && fl_cnt >= 32 && fl_cnt < 64) begin
            logic [31:0] w;
            w    = flash_word(fl_addr);
            miso = w[31 - (fl_cnt - 32)];
        end
    end

    // Session scoreboard: compare each completed chip-select window
    always @(posedge cs_n) begin
        if (fl_cnt > 0) begin
            chk("sess_expected", 32'(exp_sess.size() != 0), 32'd1);
            if (exp_sess.size() != 0) begin
                sess_t s;
                s = exp_sess.pop_front();
                chk("sess_cmd", 32'(fl_cmd), 32'(s.cmd));
                if (s.chk_addr) chk("sess_addr", 32'(fl_addr), 32'(s.addr));
                if (s.bits != 0) chk("sess_bits", 32'(fl_cnt), 32'(s.bits));
            end
        end
    end

    // ---------------- Output monitor ----------------
    int   cyc = 0, busy_cnt = 0, we_cnt = 0, we_b2b = 0;
    int   sclk_rises = 0, bad_period = 0, last_rise = -1;
    int   gap_run = 0, gap_len = -1, cs_low_cnt = 0;
    logic prev_we = 1'b0, prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (cs_n === 1'b0) cs_low_cnt++;
        if (cfg_we === 1'b1) begin
            we_cnt++;
            if (prev_we === 1'b1) we_b2b++;
            chk("bit_expected", 32'(exp_bits.size() != 0), 32'd1);
            if (exp_bits.size() != 0) chk("cfg_bit", 32'(cfg_data), 32'(exp_bits.pop_front()));
            if (we_cnt == BITS) begin
                chk("done_with_last_we", 32'(cfg_done), 32'd1);
                chk("busy_low_with_last_we", 32'(busy), 32'd0);
            end
        end
        if (sclk === 1'b1 && prev_sclk !== 1'b1) begin
            sclk_rises++;
            if (last_rise >= 0 && cyc - last_rise != 2) bad_period++;
            last_rise = cyc;
        end
        if (cs_n !== 1'b0) last_rise = -1;
        if (busy === 1'b1 && cs_n === 1'b1) gap_run++;
        else if (busy === 1'b1 && cs_n === 1'b0 && gap_run > 0) begin
            gap_len = gap_run;
            gap_run = 0;
        end
        prev_we   = cfg_we;
        prev_sclk = sclk;
    end

    task automatic push_load(input bit full);
        logic [31:0] w;
        exp_sess.push_back('{cmd: 8'hAB, addr: 24'h0, chk_addr: 1'b0, bits: 8});
        exp_sess.push_back('{cmd: 8'h03, addr: ADDR, chk_addr: 1'b1, bits: full ? 64 : 0});
        w = flash_word(ADDR);
        for (int i = 31; i >= 0; i--) exp_bits.push_back(w[i]);
    endtask

    task automatic clear_counters();
        busy_cnt = 0; we_cnt = 0; we_b2b = 0; bad_period = 0;
        gap_run = 0; gap_len = -1; sclk_rises = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (cfg_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_in_time", 32'(cfg_done), 32'd1);
    endtask

    int s0, c0;

    initial begin
        // Reset held with clock running
        repeat (6) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(cfg_we), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);

        // Idle with mode low
        rst = 1'b0;
        clear_counters();
        c0 = cs_low_cnt;
        repeat (100) @(negedge clk);
        chk("idle_sclk_rises", 32'(sclk_rises), 32'd0);
        chk("idle_cs_low", 32'(cs_low_cnt - c0), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Full load; mode wiggles mid-load are ignored
        clear_counters();
        push_load(1'b1);
        mode = 1'b1;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cs_n", 32'(cs_n), 32'd0);
        mode = 1'b0;
        repeat (30) @(negedge clk);
        mode = 1'b1;
        repeat (3) @(negedge clk);
        mode = 1'b0;
        wait_done(1000);
        @(negedge clk);
        chk("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
        chk("we_count", 32'(we_cnt), 32'(BITS));
        chk("we_back_to_back", 32'(we_b2b), 32'd0);
        chk("sclk_period", 32'(bad_period), 32'd0);
        chk("sclk_rises", 32'(sclk_rises), 32'(8 + 32 + BITS));
        chk("cs_gap", 32'(gap_len), 32'(GAP));
        chk("bits_consumed", 32'(exp_bits.size()), 32'd0);
        chk("sess_consumed", 32'(exp_sess.size()), 32'd0);

        // DONE is terminal: mode toggling does nothing
        s0 = sclk_rises;
        c0 = cs_low_cnt;
        for (int i = 0; i < 20; i++) begin
            mode = ~mode;
            repeat (2) @(negedge clk);
        end
        chk("done_no_sclk", 32'(sclk_rises - s0), 32'd0);
        chk("done_no_cs", 32'(cs_low_cnt - c0), 32'd0);
        chk("done_sticky", 32'(cfg_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);

        // Restart via reset, then abort in the middle of DATA
        mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_done", 32'(cfg_done), 32'd0);
        rst = 1'b0;
        clear_counters();
        push_load(1'b0);
        mode = 1'b1;
        begin
            int k;
            k = 0;
            while (we_cnt < 10 && k < 1000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("reached_bit10", 32'(we_cnt), 32'd10);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_done", 32'(cfg_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sclk", 32'(sclk), 32'd0);
        exp_bits.delete();
        repeat (3) @(negedge clk);
        chk("abort_sess_consumed", 32'(exp_sess.size()), 32'd0);

        // Fresh load after release, starting again at the wake command
        clear_counters();
        push_load(1'b1);
        rst = 1'b0;
        wait_done(1000);
        @(negedge clk);
        chk("rerun_busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
        chk("rerun_we_count", 32'(we_cnt), 32'(BITS));
        chk("rerun_cs_gap", 32'(gap_len), 32'(GAP));
        chk("rerun_sclk_period", 32'(bad_period), 32'd0);
        chk("rerun_sess_consumed", 32'(exp_sess.size()), 32'd0);
        chk("rerun_bits_consumed", 32'(exp_bits.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
